// File: rtl/inst_encoder_if.sv
// Field-bundle input and encoded-instruction output bundle
// for the RV32I instruction encoder.
interface inst_encoder_if #(
  parameter int DEPTH = 4
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [6:0]               opcode;
  logic [6:0]               funct7;
  logic [2:0]               funct3;
  logic [4:0]               rs1;
  logic [4:0]               rs2;
  logic [4:0]               rd;
  logic [31:0]              imm;
  logic                     out_valid;
  logic [31:0]              out_inst;
  logic                     out_ready;
  logic                     err;
  logic [7:0]               err_cnt;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    output in_valid, opcode, funct7, funct3,
    output rs1, rs2, rd, imm, out_ready,
    input  in_ready, out_valid, out_inst,
    input  err, err_cnt, level
  );

  modport slave (
    input  in_valid, opcode, funct7, funct3,
    input  rs1, rs2, rd, imm, out_ready,
    output in_ready, out_valid, out_inst,
    output err, err_cnt, level
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32I field encoder: packs R/I/S/U bundles into 32-bit
// words and queues them in a small FIFO; illegal opcodes are counted.
module inst_encoder #(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  inst_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          err_q, err_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          is_r, is_i, is_sh, is_s, is_u;
  logic          legal;
  logic [31:0]   enc;
  logic          xfer, push, pop, reject;

  assign is_sh = (bus.opcode == OP_IMM) &&
                 (bus.funct3 == 3'b001 ||
                  bus.funct3 == 3'b101);
  assign is_r  = (bus.opcode == OP_R);
  assign is_i  = ((bus.opcode == OP_IMM) && !is_sh) ||
                 (bus.opcode == OP_LOAD) ||
                 (bus.opcode == OP_JALR);
  assign is_s  = (bus.opcode == OP_STORE);
  assign is_u  = (bus.opcode == OP_LUI) ||
                 (bus.opcode == OP_AUIPC);

  always_comb begin
    legal = 1'b1;
    enc   = '0;
    unique case (1'b1)
      is_r:  enc = {bus.funct7, bus.rs2, bus.rs1,
                    bus.funct3, bus.rd, bus.opcode};
      is_sh: enc = {bus.funct7, bus.imm[4:0], bus.rs1,
                    bus.funct3, bus.rd, bus.opcode};
      is_i:  enc = {bus.imm[11:0], bus.rs1,
                    bus.funct3, bus.rd, bus.opcode};
      is_s:  enc = {bus.imm[11:5], bus.rs2, bus.rs1,
                    bus.funct3, bus.imm[4:0], bus.opcode};
      is_u:  enc = {bus.imm[31:12], bus.rd, bus.opcode};
      default: legal = 1'b0;
    endcase
  end

  // in_ready depends on registered level only: no bypass when full
  assign bus.in_ready  = (level_q < LW'(DEPTH));
  assign bus.out_valid = (level_q != '0);
  assign bus.out_inst  = bus.out_valid ? mem_q[rptr_q] : 32'h0;
  assign bus.err       = err_q;
  assign bus.err_cnt   = cnt_q;
  assign bus.level     = level_q;

  assign xfer   = bus.in_valid && bus.in_ready;
  assign push   = xfer && legal;
  assign reject = xfer && !legal;
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    err_d   = reject;
    cnt_d   = cnt_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (reject && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= enc;
    end
  end
endmodule
